dds_period_meter: RTL
=====================

// Module: dds_period_meter
// PURPOSE
//  Receive-side measurement block for the DDS signal generator: takes the 8-bit unsigned wave sample stream and
//  measures its period (samples between rising mid-level crossings, averaged over AVG_PERIODS periods).
//  Hysteresis rejects noise near midscale; loss of signal is flagged. Closes the loop on freq_word in self-test.
// PARAMETERS
//  CNT_W        24   width of per-period sample counter and of period_out
//  AVG_PERIODS  4    periods averaged per result; power of 2, 1..256
//  HYST         8    hysteresis half-width about midscale, 1..127
// PORTS
//  sys_clk       in   1      single clock
//  reset         in   1      synchronous, active-high
//  sample_valid  in   1      wave_in is valid this cycle
//  wave_in       in   8      unsigned sample, midscale 8'd128
//  period_out    out  CNT_W  averaged period in samples, holds until next result
//  period_valid  out  1      one-cycle pulse when period_out updates
//  signal_lost   out  1      level; set on timeout, cleared on next period_valid
//  peak_max      out  8      (PEAK_DETECT_EN only) max sample over last window
//  peak_min      out  8      (PEAK_DETECT_EN only) min sample over last window
// BEHAVIOUR
//  Reset (sync, active-high): period_out=0, period_valid=0, signal_lost=0, peak_max=0, peak_min=8'hFF,
//   level=0, cnt=0, acc=0, edges=0, state=SEARCH. Reset mid-window discards the partial window; no pulse.
//  All logic below advances only on cycles with sample_valid=1; otherwise all state holds.
//  Level: set when wave_in >= 128+HYST; cleared when wave_in <= 128-HYST; else holds.
//   Rising edge = level 0->1, evaluated combinationally on the same sample.
//  FSM SEARCH: cnt, acc, edges cleared; on edge -> MEASURE (this edge opens the window).
//  FSM MEASURE, per valid sample: cnt<=cnt+1, acc<=acc+1 (acc width CNT_W+log2(AVG_PERIODS)).
//   On edge: cnt<=0, edges<=edges+1. Edge that brings edges to AVG_PERIODS closes the window:
//   period_out<=(acc+1)>>log2(AVG_PERIODS), period_valid=1 the cycle after that sample, signal_lost<=0,
//   acc<=0, edges<=0, stay MEASURE (closing edge opens next window).
//  Timeout: cnt+1 reaching 2^CNT_W-1 with no edge on that sample -> signal_lost<=1, state<=SEARCH,
//   no period_valid. Edge on same sample as timeout: edge wins, no timeout.
//  Truncating divide; no rounding. Result latency: 1 cycle after closing sample.
// CONFIGURATION
//  PEAK_DETECT_EN defined: running min/max over MEASURE window samples (opening sample included, closing sample
//   included); committed to peak_max/peak_min together with period_valid; running regs reinit from the next
//   sample. Timeout leaves committed values unchanged.
//  Not defined: peak_max/peak_min ports and logic absent; the rest unchanged.
// STRUCTURE
//  Shared package dds_pkg: WAVE_W=8, WAVE_MID=8'd128, FSM state typedef {SEARCH, MEASURE}.
//  One sub-module: dds_crossing_detector (hysteresis level register + rising-edge output, gated by sample_valid).
// TESTING (bench uses CNT_W=10, AVG_PERIODS=4, HYST=8 unless stated)
//  1 Square wave 0/255, 8 low + 8 high samples, valid every cycle -> first period_valid after 4 periods
//    following first rise, period_out=16, then every 64 samples; signal_lost=0.
//  2 Same wave with sample_valid on alternate cycles -> period_out=16 (counts samples, not clocks).
//  3 Wave toggling 126/130 (inside hysteresis) -> no edges, no period_valid; timeout never fires from SEARCH.
//  4 Square wave then constant 128 -> signal_lost=1 after 1023 post-edge samples without edge; restore wave ->
//    signal_lost clears on next period_valid.
//  5 Reset pulsed mid-window (after 2 edges) -> all outputs at reset values next cycle; first result needs a full
//    new window.
//  6 PEAK_DETECT_EN, sine-like ramp 20..230 -> peak_min=20, peak_max=230 with period_valid.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types for the DDS receive-side period meter.
// Sample width, midscale, FSM state type and min/max helpers.
package dds_pkg;

  localparam int WAVE_W = 8;
  localparam logic [WAVE_W-1:0] WAVE_MID = 8'd128;

  typedef enum logic {
    SEARCH  = 1'b0,
    MEASURE = 1'b1
  } fsm_state_t;

  function automatic logic [WAVE_W-1:0] max_w(
    input logic [WAVE_W-1:0] a,
    input logic [WAVE_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic [WAVE_W-1:0] min_w(
    input logic [WAVE_W-1:0] a,
    input logic [WAVE_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/dds_period_meter_if.sv
// Sample stream in / period result out bundle.
// master: stream source + result sink; slave: the meter.
// Signals: sample_valid, wave_in, period_out, period_valid,
// signal_lost; peak_max/peak_min with PEAK_DETECT_EN.
interface dds_period_meter_if
  import dds_pkg::*;
#(
  parameter int CNT_W = 24
) ();

  logic              sample_valid;
  logic [WAVE_W-1:0] wave_in;
  logic [CNT_W-1:0]  period_out;
  logic              period_valid;
  logic              signal_lost;

`ifdef PEAK_DETECT_EN
  logic [WAVE_W-1:0] peak_max;
  logic [WAVE_W-1:0] peak_min;

  modport master (
    output sample_valid, wave_in,
    input  period_out, period_valid,
    input  signal_lost, peak_max, peak_min
  );

  modport slave (
    input  sample_valid, wave_in,
    output period_out, period_valid,
    output signal_lost, peak_max, peak_min
  );
`else
  modport master (
    output sample_valid, wave_in,
    input  period_out, period_valid,
    input  signal_lost
  );

  modport slave (
    input  sample_valid, wave_in,
    output period_out, period_valid,
    output signal_lost
  );
`endif

endinterface

// File: rtl/dds_crossing_detector.sv
// Hysteresis level tracker with rising-edge output.
// Ports: clk, reset (sync, high), sample_valid, wave_in -> rise.
// rise is combinational on the sample that sets the level.
module dds_crossing_detector
  import dds_pkg::*;
#(
  parameter int HYST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [WAVE_W-1:0] wave_in,
  output logic              rise
);

  localparam logic [WAVE_W-1:0] HI_TH =
    WAVE_W'(int'(WAVE_MID) + HYST);
  localparam logic [WAVE_W-1:0] LO_TH =
    WAVE_W'(int'(WAVE_MID) - HYST);

  logic level;
  logic hi;
  logic lo;

  assign hi   = (wave_in >= HI_TH);
  assign lo   = (wave_in <= LO_TH);
  assign rise = sample_valid && hi && !level;

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b0;
    end else if (sample_valid) begin
      if (hi) begin
        level <= 1'b1;
      end else if (lo) begin
        level <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dds_period_meter.sv
// Period meter: samples between rising mid-level crossings,
// averaged over AVG_PERIODS periods, with loss-of-signal flag.
// Ports: sys_clk, reset (sync, high), bus (slave modport).
// Optional PEAK_DETECT_EN: per-window min/max on peak_min/max.
module dds_period_meter
  import dds_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int AVG_PERIODS = 4,
  parameter int HYST        = 8
) (
  input logic               sys_clk,
  input logic               reset,
  dds_period_meter_if.slave bus
);

  localparam int AVG_LOG = $clog2(AVG_PERIODS);
  localparam int ACC_W   = CNT_W + AVG_LOG;
  localparam int EDG_W   = AVG_LOG + 1;
  localparam logic [EDG_W-1:0] EDG_LAST =
    EDG_W'(AVG_PERIODS);

  fsm_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_inc;
  logic [EDG_W-1:0] edges;
  logic [EDG_W-1:0] edges_inc;
  logic [CNT_W-1:0] avg;

  logic rise;
  logic meas;
  logic close;
  logic timeout;

  logic [CNT_W-1:0] period_q;
  logic             valid_q;
  logic             lost_q;

  dds_crossing_detector #(
    .HYST(HYST)
  ) u_xdet (
    .clk          (sys_clk),
    .reset        (reset),
    .sample_valid (bus.sample_valid),
    .wave_in      (bus.wave_in),
    .rise         (rise)
  );

  assign cnt_inc   = cnt + CNT_W'(1);
  assign acc_inc   = acc + ACC_W'(1);
  assign edges_inc = edges + EDG_W'(1);

  // Divide by a power of two: drop the low AVG_LOG bits.
  assign avg = acc_inc[ACC_W-1:AVG_LOG];

  assign meas = bus.sample_valid && (state == MEASURE);

  assign close = meas && rise &&
                 (edges_inc == EDG_LAST);

  // An edge on the timeout sample takes priority.
  assign timeout = meas && !rise && (cnt_inc == '1);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= SEARCH;
      cnt   <= '0;
      acc   <= '0;
      edges <= '0;
    end else if (bus.sample_valid) begin
      unique case (state)
        SEARCH: begin
          cnt   <= '0;
          acc   <= '0;
          edges <= '0;
          if (rise) begin
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            cnt <= '0;
            if (close) begin
              acc   <= '0;
              edges <= '0;
            end else begin
              acc   <= acc_inc;
              edges <= edges_inc;
            end
          end else if (timeout) begin
            state <= SEARCH;
          end else begin
            cnt <= cnt_inc;
            acc <= acc_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      period_q <= '0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      valid_q <= close;
      if (close) begin
        period_q <= avg;
        lost_q   <= 1'b0;
      end else if (timeout) begin
        lost_q <= 1'b1;
      end
    end
  end

  assign bus.period_out   = period_q;
  assign bus.period_valid = valid_q;
  assign bus.signal_lost  = lost_q;

`ifdef PEAK_DETECT_EN
  logic [WAVE_W-1:0] run_max;
  logic [WAVE_W-1:0] run_min;
  logic [WAVE_W-1:0] nxt_max;
  logic [WAVE_W-1:0] nxt_min;
  logic [WAVE_W-1:0] pk_max;
  logic [WAVE_W-1:0] pk_min;

  assign nxt_max = max_w(run_max, bus.wave_in);
  assign nxt_min = min_w(run_min, bus.wave_in);

  // After a commit the running regs go to their identity
  // values so the following sample restarts the window.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      run_max <= '0;
      run_min <= '1;
      pk_max  <= '0;
      pk_min  <= '1;
    end else if (bus.sample_valid) begin
      unique case (state)
        SEARCH: begin
          if (rise) begin
            run_max <= bus.wave_in;
            run_min <= bus.wave_in;
          end
        end
        MEASURE: begin
          if (close) begin
            pk_max  <= nxt_max;
            pk_min  <= nxt_min;
            run_max <= '0;
            run_min <= '1;
          end else begin
            run_max <= nxt_max;
            run_min <= nxt_min;
          end
        end
      endcase
    end
  end

  assign bus.peak_max = pk_max;
  assign bus.peak_min = pk_min;
`endif

endmodule
